// File: rtl/audioport_pkg.sv
// Shared audioport control-path definitions: register map anchor, APB wait
// limits, APB slave state encoding and the byte-strobe merge helper.
package audioport_pkg;

  localparam logic [31:0] CFG_REG_ADDRESS = 32'h8000_0100;
  localparam int unsigned APB_WAIT_MAX    = 15;
  localparam int unsigned APB_WAIT_W      = $clog2(APB_WAIT_MAX + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_t;

  // Replace byte b of old_val with new_val's byte b wherever strb[b] is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_val[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_reg_bank_checker.sv
// Protocol and write-commit properties for apb_reg_bank.
module apb_reg_bank_checker
  import audioport_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned IDX_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic                  i_commit,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [31:0]           PWDATA,
  input  logic [3:0]            PSTRB,
  input  logic [NUM_REGS*32-1:0] reg_out,
  input  logic [NUM_REGS-1:0]   wr_pulse
);

  logic [31:0]      r_exp;
  logic [IDX_W-1:0] r_idx;

  // remember what the addressed register must hold after a committing write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_exp <= 32'h0;
      r_idx <= '0;
    end else begin
      r_exp <= merge_bytes(reg_out[{i_idx, 5'b00000} +: 32], PWDATA, PSTRB);
      r_idx <= i_idx;
    end
  end

  a_commit_value: assert property (@(posedge clk) disable iff (!rst_n)
    i_commit |=> (reg_out[{r_idx, 5'b00000} +: 32] == r_exp));
  a_pulse_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(wr_pulse));
  a_ready_in_access: assert property (@(posedge clk) disable iff (!rst_n)
    PREADY |-> (PSEL && PENABLE));
  a_err_with_ready: assert property (@(posedge clk) disable iff (!rst_n)
    PSLVERR |-> PREADY);

endmodule

// File: rtl/apb_wait_timer.sv
// Access-phase wait counter: loaded at the setup phase, counts down while the
// transfer is in its access phase and flags zero when the slave may complete.
module apb_wait_timer
  import audioport_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_dec,
  input  logic [APB_WAIT_W-1:0] i_value,
  output logic                  o_zero
);

  logic [APB_WAIT_W-1:0] r_cnt;

  // load on setup, count down towards zero during the access phase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - APB_WAIT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/apb_reg_bank.sv
// APB slave register bank for the audioport control path: NUM_REGS word
// registers with byte strobes, programmable wait states, read-only slots fed
// from live inputs, error response and one-cycle per-register write pulses.
module apb_reg_bank
  import audioport_pkg::*;
#(
  parameter int unsigned          NUM_REGS    = 8,
  parameter logic [31:0]          BASE_ADDR   = CFG_REG_ADDRESS,
  parameter int unsigned          WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [31:0]            PADDR,
  input  logic [31:0]            PWDATA,
  input  logic [3:0]             PSTRB,
  output logic [31:0]            PRDATA,
  output logic                   PREADY,
  output logic                   PSLVERR,
  input  logic [NUM_REGS*32-1:0] ro_in,
  output logic [NUM_REGS*32-1:0] reg_out,
  output logic [NUM_REGS-1:0]    wr_pulse
);

  localparam int unsigned           IDX_W        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0]           REGION_BYTES = 32'(4 * NUM_REGS);
  localparam logic [APB_WAIT_W-1:0] WAIT_LOAD    = APB_WAIT_W'(WAIT_STATES);

  apb_state_t          r_state;
  logic [NUM_REGS-1:0] r_wr_pulse;
  logic                w_setup;
  logic                w_access;
  logic                w_zero;
  logic                w_done;
  logic [31:0]         w_offset;
  logic                w_hit;
  logic [IDX_W-1:0]    w_idx;
  logic                w_ro;
  logic                w_err;
  logic                w_commit;
  logic                w_unused_ro;

  assign w_setup  = (r_state == IDLE) && PSEL && !PENABLE;
  assign w_access = (r_state == ACCESS);
  // Gating with PSEL/PENABLE keeps PREADY from asserting on an abandoned access.
  assign w_done   = w_access && w_zero && PSEL && PENABLE;

  apb_wait_timer u_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_setup),
    .i_dec   (w_access),
    .i_value (WAIT_LOAD),
    .o_zero  (w_zero)
  );

  // transfer sequencing: setup moves to access, completion or deselect returns to idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            r_state <= ACCESS;
          end else begin
            r_state <= IDLE;
          end
        end
        ACCESS: begin
          if (!PSEL || w_done) begin
            r_state <= IDLE;
          end else begin
            r_state <= ACCESS;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Offset form avoids overflow of BASE_ADDR + region size at the top of the map.
  assign w_offset = PADDR - BASE_ADDR;
  assign w_hit    = (PADDR >= BASE_ADDR) && (w_offset < REGION_BYTES) && (PADDR[1:0] == 2'b00);
  assign w_idx    = w_offset[IDX_W+1:2];
  assign w_ro     = w_hit && RO_MASK[w_idx];
  assign w_err    = !w_hit || (PWRITE && w_ro);
  assign w_commit = w_done && PWRITE && !w_err;

  assign PREADY   = w_done;
  assign PSLVERR  = w_done && w_err;

  // read data is driven only for a successful read in its completing cycle
  always_comb begin
    PRDATA = 32'h0;
    if (w_done && !PWRITE && !w_err) begin
      PRDATA = reg_out[{w_idx, 5'b00000} +: 32];
    end else begin
      PRDATA = 32'h0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (RO_MASK[g]) begin : g_ro
      assign reg_out[32*g +: 32] = ro_in[32*g +: 32];
    end else begin : g_rw
      logic [31:0] r_reg;
      // byte-strobed storage updated only by a committing write to this slot
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_reg <= 32'h0;
        end else if (w_commit && (w_idx == IDX_W'(g))) begin
          r_reg <= merge_bytes(r_reg, PWDATA, PSTRB);
        end else begin
          r_reg <= r_reg;
        end
      end
      assign reg_out[32*g +: 32] = r_reg;
    end
  end

  // Live values of read-write slots are not consumed.
  assign w_unused_ro = ^ro_in;

  // one-cycle strobe for the register just written, zero strobes included
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_pulse <= '0;
    end else if (w_commit) begin
      r_wr_pulse <= NUM_REGS'(1'b1) << w_idx;
    end else begin
      r_wr_pulse <= '0;
    end
  end

  assign wr_pulse = r_wr_pulse;

  apb_reg_bank_checker #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .i_commit (w_commit),
    .i_idx    (w_idx),
    .PWDATA   (PWDATA),
    .PSTRB    (PSTRB),
    .reg_out  (reg_out),
    .wr_pulse (wr_pulse)
  );

endmodule

// File: tb/tb_apb_reg_bank.sv
// Bench for apb_reg_bank: three instances (0, 3 and 2 wait states) on a shared
// bus with private PSEL lines, directed scenarios then random transfers, all
// checked against an address-map model of the register contents.
module tb_apb_reg_bank;
  import audioport_pkg::*;

  localparam logic [31:0] BASE = CFG_REG_ADDRESS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   psel;
  logic         penable;
  logic         pwrite;
  logic [31:0]  paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [255:0] ro_in;

  logic [31:0]  prdata  [3];
  logic         pready  [3];
  logic         pslverr [3];
  logic [255:0] regout  [3];
  logic [7:0]   wrp     [3];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ws_of [3] = '{0, 3, 2};
  logic [31:0] mreg [3][8];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_reg_bank #(
      .NUM_REGS    (8),
      .BASE_ADDR   (CFG_REG_ADDRESS),
      .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 3 : 2)),
      .RO_MASK     (8'h80)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .PSEL     (psel[g]),
      .PENABLE  (penable),
      .PWRITE   (pwrite),
      .PADDR    (paddr),
      .PWDATA   (pwdata),
      .PSTRB    (pstrb),
      .PRDATA   (prdata[g]),
      .PREADY   (pready[g]),
      .PSLVERR  (pslverr[g]),
      .ro_in    (ro_in),
      .reg_out  (regout[g]),
      .wr_pulse (wrp[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_reg(input int k, input int i);
    return (i == 7) ? ro_in[255:224] : mreg[k][i];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 8; i++) mreg[k][i] = 32'h0;
  endtask

  // Address-map view: word registers at BASE + 4*i, slot 7 read-only.
  task automatic model_xfer(input int k, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb,
                            output logic exp_err, output logic [31:0] exp_rd,
                            output logic [7:0] exp_pulse);
    logic [31:0] off;
    logic        hit;
    int          idx;
    off = addr - BASE;
    hit = (addr >= BASE) && (off < 32'd32) && (addr % 4 == 0);
    idx = int'(off / 4);
    exp_err   = !hit || (wr && idx == 7);
    exp_rd    = 32'h0;
    exp_pulse = 8'h0;
    if (!exp_err) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) mreg[k][idx][8*b +: 8] = data[8*b +: 8];
        exp_pulse = 8'(1 << idx);
      end else begin
        exp_rd = exp_reg(k, idx);
      end
    end
  endtask

  // Caller is just after a rising edge; returns just after the completing edge.
  task automatic apb_xfer(input int k, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          output logic [31:0] rdata, output logic err,
                          output int waits, output int done_cyc);
    logic done;
    logic timed_out;
    psel = 3'b000; psel[k] = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(negedge clk);
    chk($sformatf("setup_pready_d%0d", k), {31'h0, pready[k]}, 32'h0);
    chk($sformatf("setup_prdata_d%0d", k), prdata[k], 32'h0);
    chk($sformatf("setup_pslverr_d%0d", k), {31'h0, pslverr[k]}, 32'h0);
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0; done = 1'b0; timed_out = 1'b0; rdata = 32'h0; err = 1'b0; done_cyc = 0;
    while (!done) begin
      @(negedge clk);
      if (pready[k]) begin
        done = 1'b1; rdata = prdata[k]; err = pslverr[k]; done_cyc = cyc;
      end else begin
        waits++;
        if (waits > 40) begin
          done = 1'b1; timed_out = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    psel = 3'b000; penable = 1'b0;
    chk($sformatf("no_timeout_d%0d", k), {31'h0, timed_out}, 32'h0);
  endtask

  task automatic check_regs(input int k, input string tag);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_reg%0d_d%0d", tag, i, k), regout[k][32*i +: 32], exp_reg(k, i));
  endtask

  // Pulse and contents in the cycle after completion, pulse gone one cycle later.
  task automatic post_check(input int k, input logic [7:0] exp_pulse, input string tag);
    @(negedge clk);
    chk($sformatf("%s_pulse_d%0d", tag, k), {24'h0, wrp[k]}, {24'h0, exp_pulse});
    check_regs(k, tag);
    @(posedge clk); #1;
    @(negedge clk);
    chk($sformatf("%s_pulse_clear_d%0d", tag, k), {24'h0, wrp[k]}, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic do_xfer(input int k, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb, input string tag);
    logic        e_err, err;
    logic [31:0] e_rd, rd;
    logic [7:0]  e_pulse;
    int          waits, dc;
    model_xfer(k, wr, addr, data, strb, e_err, e_rd, e_pulse);
    apb_xfer(k, wr, addr, data, strb, rd, err, waits, dc);
    chk({tag, "_err"}, {31'h0, err}, {31'h0, e_err});
    chk({tag, "_rdata"}, rd, e_rd);
    chk({tag, "_waits"}, waits, ws_of[k]);
    post_check(k, e_pulse, tag);
  endtask

  initial begin
    logic        e_err, err1, err2;
    logic [31:0] e_rd, rd1, rd2;
    logic [7:0]  e_pulse;
    int          w1, w2, c1, c2;

    rst_n = 1'b0; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0; ro_in = 256'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_pready_d%0d", k), {31'h0, pready[k]}, 32'h0);
      chk($sformatf("rst_prdata_d%0d", k), prdata[k], 32'h0);
      chk($sformatf("rst_pslverr_d%0d", k), {31'h0, pslverr[k]}, 32'h0);
      chk($sformatf("rst_pulse_d%0d", k), {24'h0, wrp[k]}, 32'h0);
      check_regs(k, "rst");
    end
    @(posedge clk); #1;

    // zero-wait full write, then partial-strobe merge
    do_xfer(0, 1'b1, BASE + 32'd4, 32'hA5A5_1234, 4'hF, "t1_wr");
    chk("t1_reg1", regout[0][63:32], 32'hA5A5_1234);
    do_xfer(0, 1'b1, BASE + 32'd8, 32'h1111_1111, 4'hF, "t2_init");
    do_xfer(0, 1'b1, BASE + 32'd8, 32'hFFFF_FFFF, 4'b0101, "t2_strb");
    chk("t2_reg2", regout[0][95:64], 32'h11FF_11FF);
    do_xfer(0, 1'b1, BASE + 32'd12, 32'hFFFF_FFFF, 4'h0, "zero_strb");

    // three wait states, back-to-back reads
    do_xfer(1, 1'b1, BASE + 32'd4, 32'hA5A5_1234, 4'hF, "t3_wr1");
    do_xfer(1, 1'b1, BASE + 32'd8, 32'h5555_AAAA, 4'hF, "t3_wr2");
    model_xfer(1, 1'b0, BASE + 32'd4, 32'h0, 4'h0, e_err, e_rd, e_pulse);
    apb_xfer(1, 1'b0, BASE + 32'd4, 32'h0, 4'h0, rd1, err1, w1, c1);
    apb_xfer(1, 1'b0, BASE + 32'd8, 32'h0, 4'h0, rd2, err2, w2, c2);
    chk("t3_rd1", rd1, 32'hA5A5_1234);
    chk("t3_waits1", w1, 32'd3);
    chk("t3_err1", {31'h0, err1}, 32'h0);
    chk("t3_rd2", rd2, 32'h5555_AAAA);
    chk("t3_waits2", w2, 32'd3);
    chk("t3_b2b_gap", c2 - c1, 32'd5);

    // error responses and read-only slot
    do_xfer(0, 1'b1, BASE + 32'd32, 32'hCAFE_0001, 4'hF, "t4_range");
    do_xfer(0, 1'b1, BASE + 32'd6, 32'hCAFE_0002, 4'hF, "t4_align");
    do_xfer(0, 1'b1, BASE + 32'd28, 32'hCAFE_0003, 4'hF, "t4_ro_wr");
    do_xfer(0, 1'b1, BASE - 32'd4, 32'hCAFE_0004, 4'hF, "t4_below");
    do_xfer(0, 1'b0, BASE + 32'd32, 32'h0, 4'h0, "t4_range_rd");
    ro_in[255:224] = 32'hDEAD_BEEF;
    model_xfer(0, 1'b0, BASE + 32'd28, 32'h0, 4'h0, e_err, e_rd, e_pulse);
    apb_xfer(0, 1'b0, BASE + 32'd28, 32'h0, 4'h0, rd1, err1, w1, c1);
    chk("t4_ro_rd", rd1, 32'hDEAD_BEEF);
    chk("t4_ro_err", {31'h0, err1}, 32'h0);

    // reset during a write's wait state
    do_xfer(2, 1'b1, BASE + 32'd16, 32'h0BAD_F00D, 4'hF, "t5_pre");
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'd20;
    pwdata = 32'h1234_5678; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    chk("t5_wait_pready", {31'h0, pready[2]}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; psel = 3'b000; penable = 1'b0;
    model_reset();
    @(negedge clk);
    chk("t5_pready", {31'h0, pready[2]}, 32'h0);
    chk("t5_pulse", {24'h0, wrp[2]}, 32'h0);
    for (int k = 0; k < 3; k++) check_regs(k, "t5_rst");
    @(posedge clk); #1;
    do_xfer(2, 1'b1, BASE + 32'd20, 32'h7777_1111, 4'hF, "t5_after");

    // PSEL dropped in a wait state
    do_xfer(1, 1'b1, BASE + 32'd20, 32'h2468_ACE0, 4'hF, "t6_pre");
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'd20;
    pwdata = 32'hFFFF_0000; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    chk("t6_wait_pready", {31'h0, pready[1]}, 32'h0);
    @(posedge clk); #1 psel = 3'b000; penable = 1'b0;
    @(negedge clk);
    chk("t6_drop_pready", {31'h0, pready[1]}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_pulse", {24'h0, wrp[1]}, 32'h0);
    check_regs(1, "t6_drop");
    @(posedge clk); #1;
    do_xfer(1, 1'b0, BASE + 32'd20, 32'h0, 4'h0, "t6_rd");

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      int          k;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] r;
      k    = int'($urandom_range(2, 0));
      wr   = 1'($urandom_range(1, 0));
      r    = $urandom_range(9, 0);
      addr = BASE + 32'd4 * r;
      if ($urandom_range(7, 0) == 0) addr = addr + $urandom_range(3, 1);
      for (int i = 0; i < 8; i++) ro_in[32*i +: 32] = $urandom;
      do_xfer(k, wr, addr, $urandom, 4'($urandom_range(15, 0)), $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
